// File: rtl/bg_scroll_ctrl.sv
// rtl/bg_scroll_ctrl.sv - background scroll offset, ROM address generation and level-change fade sequencer
module bg_scroll_ctrl #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        run,
  input  logic [3:0]  speed,
  input  logic        switch_req,
  input  logic        switch_sel,
  output logic [16:0] rom_address,
  output logic        bg_sel,
  output logic [3:0]  brightness,
  output logic [8:0]  scroll_x,
  output logic        busy
);

  localparam logic [9:0]  SRC_W10 = 10'(SRC_W);
  localparam logic [9:0]  SCR_W   = 10'(2 * SRC_W);
  localparam logic [9:0]  SCR_H   = 10'(2 * SRC_H);
  localparam logic [16:0] SRC_W17 = 17'(SRC_W);

  typedef enum logic [1:0] {RUN, FADE_OUT, FADE_IN} state_t;

  state_t      state, state_n;
  logic [3:0]  bright_n;
  logic        bg_n, target, target_n;
  logic [8:0]  scroll_n;

  logic        at_origin, prev_origin, tick;
  logic [8:0]  sx, sy;
  logic [9:0]  x_sum, x_wrap, s_sum, s_wrap;
  logic [16:0] addr_next;

  // Tick only on the first cycle (0,0) is seen, so a held origin cannot re-fire.
  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_origin <= 1'b0;
      tick        <= 1'b0;
    end else begin
      prev_origin <= at_origin;
      tick        <= at_origin && !prev_origin;
    end
  end

  assign sx     = DrawX[9:1];
  assign sy     = DrawY[9:1];
  assign x_sum  = {1'b0, sx} + {1'b0, scroll_x};
  assign x_wrap = (x_sum >= SRC_W10) ? x_sum - SRC_W10 : x_sum;

  always_comb begin
    addr_next = '0;
    if (DrawX < SCR_W && DrawY < SCR_H)
      addr_next = 17'(sy) * SRC_W17 + 17'(x_wrap);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) rom_address <= '0;
    else          rom_address <= addr_next;
  end

  assign s_sum  = {1'b0, scroll_x} + {6'd0, speed};
  assign s_wrap = (s_sum >= SRC_W10) ? s_sum - SRC_W10 : s_sum;

  always_comb begin
    state_n  = state;
    bright_n = brightness;
    bg_n     = bg_sel;
    target_n = target;
    scroll_n = scroll_x;
    if (tick && run)
      scroll_n = s_wrap[8:0];
    case (state)
      RUN: begin
        if (switch_req && (switch_sel != bg_sel)) begin
          target_n = switch_sel;
          state_n  = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (tick) begin
          if (brightness != 4'd0) begin
            bright_n = brightness - 4'd1;
          end else begin
            // Swap tick: new image starts from its left edge, no scroll step.
            bg_n     = target;
            scroll_n = '0;
            state_n  = FADE_IN;
          end
        end
      end
      FADE_IN: begin
        if (tick) begin
          bright_n = brightness + 4'd1;
          if (brightness == 4'd14)
            state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      brightness <= 4'd15;
      bg_sel     <= 1'b0;
      target     <= 1'b0;
      scroll_x   <= '0;
    end else begin
      state      <= state_n;
      brightness <= bright_n;
      bg_sel     <= bg_n;
      target     <= target_n;
      scroll_x   <= scroll_n;
    end
  end

  assign busy = (state != RUN);

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// tb/tb_bg_scroll_ctrl.sv - directed scoreboard bench for bg_scroll_ctrl
module tb_bg_scroll_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        run;
  logic [3:0]  speed;
  logic        switch_req, switch_sel;
  logic [16:0] rom_address;
  logic        bg_sel;
  logic [3:0]  brightness;
  logic [8:0]  scroll_x;
  logic        busy;

  bg_scroll_ctrl #(.SRC_W(320), .SRC_H(240)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .run(run), .speed(speed), .switch_req(switch_req), .switch_sel(switch_sel),
    .rom_address(rom_address), .bg_sel(bg_sel), .brightness(brightness),
    .scroll_x(scroll_x), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   es;
  int   eb;
  logic ebg;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic int wrap_step(input int s, input int sp);
    return (s + sp >= 320) ? s + sp - 320 : s + sp;
  endfunction

  // One frame tick: origin presented for one cycle; sample after the tick cycle's edge.
  task automatic frame_tick();
    @(negedge vga_clk);
    DrawX = 10'd0;
    DrawY = 10'd0;
    @(negedge vga_clk);
    DrawX = 10'd5;
    DrawY = 10'd5;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_switch(input logic sel);
    @(negedge vga_clk);
    switch_req = 1'b1;
    switch_sel = sel;
    @(posedge vga_clk);
    #1;
    switch_req = 1'b0;
  endtask

  task automatic set_pixel(input int x, input int y);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    push({tag, "_bright"}, 32'(eb));     compare(32'(brightness));
    push({tag, "_scroll"}, 32'(es));     compare(32'(scroll_x));
    push({tag, "_bg_sel"}, 32'(ebg));    compare(32'(bg_sel));
  endtask

  initial begin
    reset_n = 1'b0;
    DrawX = 10'd5; DrawY = 10'd5;
    run = 1'b0; speed = 4'd0;
    switch_req = 1'b0; switch_sel = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    push("rst_rom", 0);       compare(32'(rom_address));
    push("rst_bg_sel", 0);    compare(32'(bg_sel));
    push("rst_bright", 15);   compare(32'(brightness));
    push("rst_scroll", 0);    compare(32'(scroll_x));
    push("rst_busy", 0);      compare(32'(busy));
    @(negedge vga_clk);
    reset_n = 1'b1;
    es = 0; eb = 15; ebg = 1'b0;

    // Address mapping
    set_pixel(639, 479);  push("addr_max", 76799);  compare(32'(rom_address));
    set_pixel(700, 100);  push("addr_xoff", 0);     compare(32'(rom_address));
    set_pixel(100, 480);  push("addr_yoff", 0);     compare(32'(rom_address));
    set_pixel(100, 50);   push("addr_mid", 8050);   compare(32'(rom_address));

    // Pause then resume
    speed = 4'd5;
    for (int i = 0; i < 3; i++) begin
      frame_tick();
      push("pause_scroll", 0); compare(32'(scroll_x));
    end
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame_tick();
      es = wrap_step(es, 5);
      push("resume_scroll", 32'(es)); compare(32'(scroll_x));
    end

    // Drive the offset to 316, then wrap with speed 8
    speed = 4'd15;
    for (int i = 0; i < 20; i++) begin
      frame_tick();
      es = wrap_step(es, 15);
    end
    speed = 4'd6;
    frame_tick();
    es = wrap_step(es, 6);
    push("pre_wrap", 316); compare(32'(scroll_x));
    speed = 4'd8;
    frame_tick();
    es = wrap_step(es, 8);
    push("wrap_scroll", 4); compare(32'(scroll_x));
    set_pixel(630, 0);  push("wrap_addr", 319); compare(32'(rom_address));
    set_pixel(630, 2);  push("wrap_addr_y1", 639); compare(32'(rom_address));

    // Request for the already-selected background is ignored
    speed = 4'd2;
    pulse_switch(1'b0);
    push("ign_busy", 0); compare(32'(busy));
    frame_tick();
    es = wrap_step(es, 2);
    check_status("ign");
    push("ign_busy2", 0); compare(32'(busy));

    // Full fade to background2, with a stray request mid-fade
    pulse_switch(1'b1);
    push("fade_busy_rise", 1); compare(32'(busy));
    for (int t = 1; t <= 31; t++) begin
      if (t == 5) pulse_switch(1'b0);
      frame_tick();
      if (t <= 15) begin
        eb = 15 - t;
        es = wrap_step(es, 2);
      end else if (t == 16) begin
        ebg = 1'b1;
        es = 0;
      end else begin
        eb = t - 16;
        es = wrap_step(es, 2);
      end
      check_status($sformatf("fade_t%0d", t));
      push($sformatf("fade_busy_t%0d", t), (t < 31) ? 1 : 0); compare(32'(busy));
    end
    frame_tick();
    es = wrap_step(es, 2);
    check_status("post_fade");

    // Reset while fading back out
    pulse_switch(1'b0);
    push("rf_busy", 1); compare(32'(busy));
    for (int t = 1; t <= 9; t++) begin
      frame_tick();
      eb = 15 - t;
      es = wrap_step(es, 2);
    end
    check_status("rf_pre");
    set_pixel(100, 50);
    push("rf_addr_pre", 32'(8000 + ((50 + es) % 320))); compare(32'(rom_address));
    #2;
    reset_n = 1'b0;
    #1;
    push("rf_rom", 0);      compare(32'(rom_address));
    push("rf_bg_sel", 0);   compare(32'(bg_sel));
    push("rf_bright", 15);  compare(32'(brightness));
    push("rf_scroll", 0);   compare(32'(scroll_x));
    push("rf_busy0", 0);    compare(32'(busy));
    @(negedge vga_clk);
    reset_n = 1'b1;
    es = 0; eb = 15; ebg = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      frame_tick();
      es = wrap_step(es, 2);
    end
    check_status("after_rst");
    push("after_rst_busy", 0); compare(32'(busy));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
